if_id_pipe_reg: RTL

- Parametrised IF/ID pipeline register with a valid/ready handshake on both sides, synchronous flush, and an optional one-entry skid buffer that keeps `in_ready` registered.
- Carries instruction, PC and PC+4 from fetch to decode.
- Inserts NOP bubbles on empty and on flush.
- Counts backpressure (stall) cycles.
- Placement: between the instruction-fetch stage and the decode stage of the RV32IM pipeline.

---
 rtl/rv_pipe_pkg.sv | 20 ++
 rtl/if_id_pipe_reg_if.sv | 25 ++
 rtl/pipe_skid_buffer.sv | 94 +++++++++
 rtl/if_id_pipe_reg.sv | 66 ++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the RV32IM front end: defaults, bubble
// instruction, buffer occupancy states and the IF/ID payload layout.
package rv_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } if_id_payload_t;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Fetch-to-decode handshake bundle: input side from IF, output side towards ID.
interface if_id_pipe_reg_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PC4;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] instruction_out;
    logic [XLEN-1:0] PC_out;
    logic [XLEN-1:0] PC4_out;

    modport slave (
        input  in_valid, instruction, PC, PC4, out_ready,
        output in_ready, out_valid, instruction_out, PC_out, PC4_out
    );

    modport master (
        output in_valid, instruction, PC, PC4, out_ready,
        input  in_ready, out_valid, instruction_out, PC_out, PC4_out
    );
endinterface

// File: rtl/pipe_skid_buffer.sv
// Generic valid/ready pipeline stage with flush; SKID=1 adds a spare entry so
// that in_ready comes straight from a flop instead of from out_ready.
module pipe_skid_buffer
    import rv_pipe_pkg::*;
#(
    parameter int W    = 96,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    pipe_state_e state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         in_acc_s, out_acc_s;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_ready  = SKID ? in_ready_q : (!out_valid || out_ready);
    assign in_acc_s  = in_valid && in_ready;
    assign out_acc_s = out_valid && out_ready;

    // Occupancy state, both payload slots and the registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= {W{1'b0}};
            skid_q     <= {W{1'b0}};
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next occupancy; payload slots keep their contents when not reloaded.
    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        in_ready_d = 1'b1;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_acc_s) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (in_acc_s && out_acc_s) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end else if (in_acc_s) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (out_acc_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    if (out_acc_s) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: buffers {instruction, PC, PC+4}, shows a NOP bubble
// whenever decode has nothing valid, and counts decode backpressure cycles.
module if_id_pipe_reg #(
    parameter int              XLEN      = rv_pipe_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR,
    parameter bit              SKID      = 1'b1,
    parameter int              CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              flush,
    if_id_pipe_reg_if.slave   bus,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int W = 3 * XLEN;

    logic [W-1:0]     in_data_s;
    logic [W-1:0]     out_data_s;
    logic             out_valid_s;
    logic [CNT_W-1:0] stall_q, stall_d;

    assign in_data_s = {bus.instruction, bus.PC, bus.PC4};

    pipe_skid_buffer #(
        .W    (W),
        .SKID (SKID)
    ) u_buf (
        .clk       (CLK),
        .rst       (RESET),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_data_s),
        .out_valid (out_valid_s),
        .out_ready (bus.out_ready),
        .out_data  (out_data_s)
    );

    // PC fields keep the last entry on empty; only the instruction becomes a bubble.
    assign bus.out_valid       = out_valid_s;
    assign bus.instruction_out = out_valid_s ? out_data_s[W-1 -: XLEN] : NOP_INSTR;
    assign bus.PC_out          = out_data_s[2*XLEN-1 -: XLEN];
    assign bus.PC4_out         = out_data_s[XLEN-1:0];
    assign stall_cycles        = stall_q;

    // Stall counter register; flush deliberately leaves it alone.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_q <= {CNT_W{1'b0}};
        end else begin
            stall_q <= stall_d;
        end
    end

    // Saturating increment on every cycle decode holds off a valid entry.
    always_comb begin
        stall_d = stall_q;
        if (out_valid_s && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

endmodule
